m_compress: RTL and testbench

//   Sequential inverse of the 16->32 sign-extender: takes 32-bit words over a valid/ready

---
 rtl/m_pkg.sv | 14 +
 rtl/m_is_sext.sv | 14 +
 rtl/m_compress.sv | 128 ++++++++++++
 tb/tb_m_compress.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/m_pkg.sv
// Shared types and widths for the halfword compressor.
// Imported by the sign-extension checker and the compressor top.
package m_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND_LO,
        SEND_HI
    } cmp_state_t;

    localparam int HW = 16;
    localparam int WW = 32;

endpackage

// File: rtl/m_is_sext.sv
// Combinational test: is the upper half of a word the sign
// extension of its lower half?
module m_is_sext
    import m_pkg::*;
#(
    parameter int HW_P = HW
) (
    input  logic [2*HW_P-1:0] w,
    output logic              is_sext
);

    assign is_sext = (w[2*HW_P-1:HW_P] == {HW_P{w[HW_P-1]}});

endmodule

// File: rtl/m_compress.sv
// Splits 32-bit words into 16-bit beats; words that are a
// sign-extended halfword go out as a single compact beat.
module m_compress
    import m_pkg::*;
#(
    parameter int W_OUT   = HW,
    parameter int COMPACT = 1,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*W_OUT-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W_OUT-1:0]   out_data,
    output logic               out_compact,
    output logic               out_last,
    output logic [CNT_W-1:0]   cnt_words,
    output logic [CNT_W-1:0]   cnt_compact
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    cmp_state_t         state;
    cmp_state_t         state_nx;
    logic [2*W_OUT-1:0] word;
    logic               cflag;
    logic               sext;
    logic               in_cmp;
    logic               take;
    logic               accept;

    m_is_sext #(
        .HW_P    (W_OUT)
    ) u_sext (
        .w       (in_data),
        .is_sext (sext)
    );

    assign in_cmp = (COMPACT != 0) && sext;

    // A new word may enter in the same cycle the final beat leaves.
    assign take     = out_valid && out_ready;
    assign in_ready = (state == IDLE) || (take && out_last);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = SEND_LO;
                end
            end
            SEND_LO: begin
                if (take) begin
                    if (!cflag) begin
                        state_nx = SEND_HI;
                    end else begin
                        state_nx = accept ? SEND_LO : IDLE;
                    end
                end
            end
            SEND_HI: begin
                if (take) begin
                    state_nx = accept ? SEND_LO : IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        out_valid   = 1'b0;
        out_data    = '0;
        out_compact = 1'b0;
        out_last    = 1'b0;
        unique case (1'b1)
            state == SEND_LO: begin
                out_valid   = 1'b1;
                out_data    = word[W_OUT-1:0];
                out_compact = cflag;
                out_last    = cflag;
            end
            state == SEND_HI: begin
                out_valid   = 1'b1;
                out_data    = word[2*W_OUT-1:W_OUT];
                out_last    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word  <= '0;
            cflag <= 1'b0;
        end else if (accept) begin
            word  <= in_data;
            cflag <= in_cmp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_words   <= '0;
            cnt_compact <= '0;
        end else if (accept) begin
            if (cnt_words != CNT_MAX) begin
                cnt_words <= cnt_words + 1'b1;
            end
            if (in_cmp && cnt_compact != CNT_MAX) begin
                cnt_compact <= cnt_compact + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_m_compress.sv
// Scoreboard bench for m_compress: default instance plus a
// COMPACT=0 / narrow-counter instance for saturation.
module tb_m_compress;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_compact;
    logic        out_last;
    logic [15:0] cnt_words;
    logic [15:0] cnt_compact;

    logic        in1_valid;
    logic        in1_ready;
    logic [31:0] in1_data;
    logic        out1_valid;
    logic        out1_ready;
    logic [15:0] out1_data;
    logic        out1_compact;
    logic        out1_last;
    logic [1:0]  cnt1_words;
    logic [1:0]  cnt1_compact;

    int n_cmp;
    int n_bad;
    logic [17:0] sb[$];
    logic [17:0] sb1[$];
    logic [31:0] stim_q[$];
    bit          ir_log[$];
    int          exp_words;
    int          exp_compact;
    int          first_beat;
    int          last_beat;

    m_compress dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_compact (out_compact),
        .out_last    (out_last),
        .cnt_words   (cnt_words),
        .cnt_compact (cnt_compact)
    );

    m_compress #(
        .W_OUT   (16),
        .COMPACT (0),
        .CNT_W   (2)
    ) dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in1_valid),
        .in_ready    (in1_ready),
        .in_data     (in1_data),
        .out_valid   (out1_valid),
        .out_ready   (out1_ready),
        .out_data    (out1_data),
        .out_compact (out1_compact),
        .out_last    (out1_last),
        .cnt_words   (cnt1_words),
        .cnt_compact (cnt1_compact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit exp_cmp(input logic [31:0] w, input bit en);
        return en && (w[31:15] == 17'h0 || w[31:15] == 17'h1ffff);
    endfunction

    // Expected beats are packed as {data, compact, last}.
    task automatic push_word(input logic [31:0] w);
        if (exp_cmp(w, 1'b1)) begin
            sb.push_back({w[15:0], 1'b1, 1'b1});
            exp_compact++;
        end else begin
            sb.push_back({w[15:0], 1'b0, 1'b0});
            sb.push_back({w[31:16], 1'b0, 1'b1});
        end
        exp_words++;
    endtask

    // Feeds stim_q with an optional idle gap; called just after a posedge.
    task automatic run_stream(input string name, input int gap);
        int idx;
        int wait_n;
        int cyc;
        logic [17:0] e;
        idx = 0;
        wait_n = 0;
        cyc = 0;
        first_beat = -1;
        last_beat = -1;
        ir_log.delete();
        out_ready = 1'b1;
        while (cyc < 200) begin
            if (idx < stim_q.size() && wait_n == 0) begin
                in_valid = 1'b1;
                in_data = stim_q[idx];
            end else begin
                in_valid = 1'b0;
                in_data = $urandom;
            end
            @(negedge clk);
            ir_log.push_back(in_ready);
            if (out_valid && out_ready) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL %s unexpected beat: got %h", name, out_data);
                end else begin
                    e = sb.pop_front();
                    if ({out_data, out_compact, out_last} !== e) begin
                        n_bad++;
                        $display("FAIL %s beat: got %h c%b l%b, want %h c%b l%b",
                                 name, out_data, out_compact, out_last,
                                 e[17:2], e[1], e[0]);
                    end
                end
                if (first_beat < 0) first_beat = cyc;
                last_beat = cyc;
            end
            if (in_valid && in_ready) begin
                push_word(in_data);
                idx++;
                wait_n = gap;
            end else if (wait_n > 0) begin
                wait_n--;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (idx == stim_q.size() && sb.size() == 0 && !out_valid) break;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (cyc >= 200 || sb.size() != 0) begin
            n_bad++;
            $display("FAIL %s timeout: %0d beats left, want 0", name, sb.size());
        end
        n_cmp++;
        if (cnt_words !== exp_words[15:0] || cnt_compact !== exp_compact[15:0]) begin
            n_bad++;
            $display("FAIL %s counters: got %0d/%0d, want %0d/%0d", name,
                     cnt_words, cnt_compact, exp_words, exp_compact);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;
        in1_valid = 1'b0;
        in1_data = '0;
        out1_ready = 1'b1;
        exp_words = 0;
        exp_compact = 0;
        #1;
        n_cmp++;
        if ({out_valid, out_data, out_compact, out_last} !== 19'h0) begin
            n_bad++;
            $display("FAIL reset outputs: got v%b %h c%b l%b, want all 0",
                     out_valid, out_data, out_compact, out_last);
        end
        n_cmp++;
        if (cnt_words !== 16'h0 || cnt_compact !== 16'h0) begin
            n_bad++;
            $display("FAIL reset counters: got %0d/%0d, want 0/0",
                     cnt_words, cnt_compact);
        end
        n_cmp++;
        if (in_ready !== 1'b1 || out1_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset ready: got in_ready=%b v1=%b, want 1/0",
                     in_ready, out1_valid);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_compact();
        stim_q = '{32'h0000_1234, 32'hFFFF_8001, 32'h0000_7FFF};
        run_stream("compact", 2);
    endtask

    task automatic test_wide();
        stim_q = '{32'h0000_8000, 32'hDEAD_BEEF, 32'hFFFF_7FFF};
        run_stream("wide", 1);
    endtask

    task automatic test_back_to_back();
        logic [4:0] irv;
        stim_q = '{32'h0000_1234, 32'hFFFF_8001, 32'hDEAD_BEEF};
        run_stream("b2b", 0);
        irv = '0;
        for (int i = 0; i < 5; i++) begin
            if (i < ir_log.size()) irv[4-i] = ir_log[i];
        end
        n_cmp++;
        if (irv !== 5'b11101) begin
            n_bad++;
            $display("FAIL b2b in_ready: got %b, want 11101", irv);
        end
        n_cmp++;
        if (last_beat - first_beat + 1 != 4) begin
            n_bad++;
            $display("FAIL b2b span: got %0d cycles, want 4",
                     last_beat - first_beat + 1);
        end
    endtask

    task automatic test_stall();
        logic [17:0] e;
        logic [17:0] held;
        sb.delete();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 32'hDEAD_BEEF;
        @(negedge clk);
        if (in_valid && in_ready) push_word(in_data);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data = 32'h5555_5555;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) held = (sb.size() > 0) ? sb[0] : 18'h0;
            n_cmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                {out_data, out_compact, out_last} !== held) begin
                n_bad++;
                $display("FAIL stall cycle %0d: got v%b r%b %h c%b l%b, want v1 r0 %h c%b l%b",
                         k, out_valid, in_ready, out_data, out_compact, out_last,
                         held[17:2], held[1], held[0]);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_cmp++;
            e = (sb.size() > 0) ? sb.pop_front() : 18'h0;
            if (!out_valid || {out_data, out_compact, out_last} !== e) begin
                n_bad++;
                $display("FAIL stall beat %0d: got v%b %h c%b l%b, want %h c%b l%b",
                         k, out_valid, out_data, out_compact, out_last,
                         e[17:2], e[1], e[0]);
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || cnt_words !== exp_words[15:0]) begin
            n_bad++;
            $display("FAIL stall end: got v%b words %0d, want v0 words %0d",
                     out_valid, cnt_words, exp_words);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        logic [17:0] e;
        sb.delete();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 32'hDEAD_BEEF;
        @(negedge clk);
        if (in_valid && in_ready) push_word(in_data);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        e = (sb.size() > 0) ? sb.pop_front() : 18'h0;
        if (!out_valid || {out_data, out_compact, out_last} !== e) begin
            n_bad++;
            $display("FAIL rstmid lo beat: got v%b %h, want %h",
                     out_valid, out_data, e[17:2]);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, out_data, out_last} !== 18'h0) begin
            n_bad++;
            $display("FAIL rstmid outputs: got v%b %h l%b, want all 0",
                     out_valid, out_data, out_last);
        end
        n_cmp++;
        if (cnt_words !== 16'h0 || cnt_compact !== 16'h0) begin
            n_bad++;
            $display("FAIL rstmid counters: got %0d/%0d, want 0/0",
                     cnt_words, cnt_compact);
        end
        sb.delete();
        exp_words = 0;
        exp_compact = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL rstmid ghost beat: got v%b %h, want v0",
                         out_valid, out_data);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_no_compact();
        logic [31:0] ws[$];
        logic [17:0] e;
        int idx;
        int cyc;
        int exp1;
        ws = '{32'h0000_0001, 32'h0000_1234, 32'hFFFF_8001, 32'h0};
        idx = 0;
        cyc = 0;
        exp1 = 0;
        sb1.delete();
        out1_ready = 1'b1;
        while (cyc < 100) begin
            in1_valid = (idx < ws.size());
            in1_data = (idx < ws.size()) ? ws[idx] : 32'h0;
            @(negedge clk);
            if (out1_valid && out1_ready) begin
                n_cmp++;
                e = (sb1.size() > 0) ? sb1.pop_front() : 18'h0;
                if ({out1_data, out1_compact, out1_last} !== e) begin
                    n_bad++;
                    $display("FAIL nocmp beat: got %h c%b l%b, want %h c%b l%b",
                             out1_data, out1_compact, out1_last,
                             e[17:2], e[1], e[0]);
                end
            end
            if (in1_valid && in1_ready) begin
                sb1.push_back({in1_data[15:0], 1'b0, 1'b0});
                sb1.push_back({in1_data[31:16], 1'b0, 1'b1});
                if (exp1 < 3) exp1++;
                idx++;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (idx == ws.size() && sb1.size() == 0 && !out1_valid) break;
        end
        in1_valid = 1'b0;
        n_cmp++;
        if (cyc >= 100 || sb1.size() != 0) begin
            n_bad++;
            $display("FAIL nocmp timeout: %0d beats left, want 0", sb1.size());
        end
        n_cmp++;
        if (cnt1_words !== exp1[1:0] || cnt1_compact !== 2'd0) begin
            n_bad++;
            $display("FAIL nocmp counters: got %0d/%0d, want %0d/0",
                     cnt1_words, cnt1_compact, exp1);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_compact();
        test_wide();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_no_compact();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
